// File: rtl/ov7670_config_seq.sv
// OV7670 register configuration sequencer: walks a synchronous ROM of
// {reg, value} words, issues SCCB write requests, and honours delay/end markers.
module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_valid,
    input  logic        sccb_ready,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    // Handshake: sccb_valid is a pure function of state (high only in SEND);
    // reg/val hold steady while valid is high, and the request is consumed on
    // the cycle where sccb_valid && sccb_ready.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        SEND   = 3'd3,
        DELAY  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int unsigned DLY_EFF  = (DELAY_CYCLES == 0) ? 1 : DELAY_CYCLES;
    localparam logic [19:0] DLY_LOAD = 20'(DLY_EFF - 1);

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  sccb_reg_q, sccb_reg_d;
    logic [7:0]  sccb_val_q, sccb_val_d;
    logic [19:0] dly_q, dly_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= 8'd0;
            sccb_reg_q <= 8'd0;
            sccb_val_q <= 8'd0;
            dly_q      <= 20'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            sccb_reg_q <= sccb_reg_d;
            sccb_val_q <= sccb_val_d;
            dly_q      <= dly_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        sccb_reg_d = sccb_reg_q;
        sccb_val_d = sccb_val_q;
        dly_d      = dly_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rom_addr_d = 8'd0;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data == 16'hFFFF) begin
                    state_d = DONE;
                end else if (rom_data == 16'hFFF0) begin
                    dly_d   = DLY_LOAD;
                    state_d = DELAY;
                end else begin
                    sccb_reg_d = rom_data[15:8];
                    sccb_val_d = rom_data[7:0];
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (sccb_ready) begin
                    // The last ROM slot terminates the run rather than wrapping to 0.
                    if (rom_addr_q == 8'hFF) begin
                        state_d = DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + 8'd1;
                        state_d    = FETCH;
                    end
                end
            end
            DELAY: begin
                if (dly_q == 20'd0) begin
                    if (rom_addr_q == 8'hFF) begin
                        state_d = DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + 8'd1;
                        state_d    = FETCH;
                    end
                end else begin
                    dly_d = dly_q - 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_valid = (state_q == SEND);
    assign sccb_reg   = sccb_reg_q;
    assign sccb_val   = sccb_val_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq: ROM model, handshake monitor and
// scripted scenarios with hand-computed expectations.
module tb_ov7670_config_seq;

    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid;
    logic        sccb_ready;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    ov7670_config_seq #(.DELAY_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_valid (sccb_valid),
        .sccb_ready (sccb_ready),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock / ROM model
    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // monitor
    int          cyc = 0;
    int          dly_cnt = 0;
    int          valid_cnt = 0;
    logic [15:0] got_q[$];
    int          hs_cyc[$];
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sccb_valid && sccb_ready) begin
            got_q.push_back({sccb_reg, sccb_val});
            hs_cyc.push_back(cyc);
        end
        if (dbg_state == 3'd4) dly_cnt <= dly_cnt + 1;
        if (sccb_valid) valid_cnt <= valid_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] st, input int max, input string tag);
        int n = 0;
        while (dbg_state !== st && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, dbg_state}, {29'd0, st});
    endtask

    // compares requests captured since 'base' against exp_q, then empties exp_q
    task automatic compare_got(input string tag, input int base);
        check({tag, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_req%0d", tag, i), {16'd0, got_q[base + i]}, {16'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    initial begin
        int base;
        int vb;
        logic [7:0] b;

        rst_n = 1'b0;
        start = 1'b0;
        sccb_ready = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_addr",  {24'd0, rom_addr}, 32'd0);
        check("rst_valid", {31'd0, sccb_valid}, 32'd0);
        check("rst_reg",   {24'd0, sccb_reg}, 32'd0);
        check("rst_val",   {24'd0, sccb_val}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", {29'd0, dbg_state}, 32'd0);

        // basic table with a delay entry
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1200; rom[3] = 16'hFFFF;
        base = got_q.size();
        vb = dly_cnt;
        pulse_start();
        check("a_busy", {31'd0, busy}, 32'd1);
        wait_done(200, "a_done");
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        compare_got("a", base);
        check("a_addr", {24'd0, rom_addr}, 32'd3);
        check("a_delay_cycles", dly_cnt - vb, DC);
        if (got_q.size() >= base + 2)
            check("a_hs_gap", hs_cyc[base + 1] - hs_cyc[base], DC + 5);

        // back-pressure during SEND
        rom[0] = 16'h3456; rom[1] = 16'hFFFF;
        sccb_ready = 1'b0;
        base = got_q.size();
        pulse_start();
        wait_state(3'd3, 20, "b_send");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b_valid%0d", i), {31'd0, sccb_valid}, 32'd1);
            check($sformatf("b_reg%0d", i), {24'd0, sccb_reg}, 32'h34);
            check($sformatf("b_val%0d", i), {24'd0, sccb_val}, 32'h56);
            @(negedge clk);
        end
        check("b_no_hs", got_q.size() - base, 32'd0);
        sccb_ready = 1'b1;
        @(negedge clk);
        check("b_one_hs", got_q.size() - base, 32'd1);
        check("b_valid_low", {31'd0, sccb_valid}, 32'd0);
        wait_done(50, "b_done");
        exp_q.push_back(16'h3456);
        compare_got("b", base);

        // full 256-entry table without an end marker
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            rom[i] = {b, ~b};
            exp_q.push_back({b, ~b});
        end
        base = got_q.size();
        pulse_start();
        wait_done(1500, "c_done");
        compare_got("c", base);
        check("c_addr", {24'd0, rom_addr}, 32'hFF);
        vb = valid_cnt;
        repeat (10) @(negedge clk);
        check("c_no_257th", valid_cnt - vb, 32'd0);
        check("c_still_done", {31'd0, done}, 32'd1);

        // asynchronous reset while counting down a delay
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'hA55A; rom[1] = 16'hFFF0; rom[2] = 16'h1111;
        base = got_q.size();
        pulse_start();
        wait_state(3'd4, 30, "d_delay");
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("d_state", {29'd0, dbg_state}, 32'd0);
        check("d_addr",  {24'd0, rom_addr}, 32'd0);
        check("d_valid", {31'd0, sccb_valid}, 32'd0);
        check("d_reg",   {24'd0, sccb_reg}, 32'd0);
        check("d_val",   {24'd0, sccb_val}, 32'd0);
        check("d_busy",  {31'd0, busy}, 32'd0);
        check("d_done",  {31'd0, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("d_idle_state", {29'd0, dbg_state}, 32'd0);
        check("d_idle_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(16'hA55A);
        compare_got("d", base);

        // start held during SEND, then a repeat run from DONE
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1200; rom[3] = 16'hFFFF;
        sccb_ready = 1'b0;
        base = got_q.size();
        pulse_start();
        wait_state(3'd3, 20, "e_send");
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("e_hold_addr%0d", i), {24'd0, rom_addr}, 32'd0);
            check($sformatf("e_hold_valid%0d", i), {31'd0, sccb_valid}, 32'd1);
        end
        start = 1'b0;
        sccb_ready = 1'b1;
        wait_done(200, "e_done1");
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        compare_got("e1", base);
        check("e_addr1", {24'd0, rom_addr}, 32'd3);
        base = got_q.size();
        pulse_start();
        check("e_restart_addr", {24'd0, rom_addr}, 32'd0);
        check("e_restart_fetch", {29'd0, dbg_state}, 32'd1);
        wait_done(200, "e_done2");
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        compare_got("e2", base);
        check("e_addr2", {24'd0, rom_addr}, 32'd3);

        // end marker at address 0
        rom[0] = 16'hFFFF;
        vb = valid_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("f_fetch", {29'd0, dbg_state}, 32'd1);
        check("f_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("f_decode", {29'd0, dbg_state}, 32'd2);
        check("f_not_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("f_done", {31'd0, done}, 32'd1);
        check("f_busy_low", {31'd0, busy}, 32'd0);
        check("f_addr", {24'd0, rom_addr}, 32'd0);
        check("f_no_valid", valid_cnt - vb, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
